// File: rtl/sequencer_pkg.sv
// Shared types for the program sequencer: controller states and the
// strobe-priority encoding used to pick one PC action per enabled cycle.
package sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } seq_state_t;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_INC  = 3'd1,
    ACT_JUMP = 3'd2,
    ACT_CALL = 3'd3,
    ACT_RET  = 3'd4,
    ACT_HALT = 3'd5
  } pc_action_t;

  // Highest-priority strobe wins; jump masks a simultaneous increment.
  function automatic pc_action_t decode_action(
    input logic halt,
    input logic ret,
    input logic call,
    input logic jump,
    input logic inc
  );
    if (halt)      return ACT_HALT;
    else if (ret)  return ACT_RET;
    else if (call) return ACT_CALL;
    else if (jump) return ACT_JUMP;
    else if (inc)  return ACT_INC;
    else           return ACT_NONE;
  endfunction

endpackage

// File: rtl/program_sequencer_call_stack.sv
// LIFO holding return addresses; entries are unreset and only become visible
// on top once pushed, the occupancy count is the only reset state.
module call_stack #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int DEPTH_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       top,
  output logic [DEPTH_WIDTH-1:0] depth,
  output logic                   full,
  output logic                   empty
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] count;
  logic [DEPTH_WIDTH-1:0] top_idx;

  assign top_idx = count - 1'b1;
  assign full    = (count == DEPTH_WIDTH'(DEPTH));
  assign empty   = (count == '0);
  assign depth   = count;
  assign top     = empty ? '0 : mem[top_idx[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[count[ADDR_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (push && !full)
      count <= count + 1'b1;
    else if (pop && !empty)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter, micro-step counter and call/return controller; halt and
// fault are absorbing states that freeze everything until reset.
module program_sequencer
  import sequencer_pkg::*;
#(
  parameter int PC_WIDTH          = 4,
  parameter int INSTRUCTION_STEPS = 8,
  parameter int STACK_DEPTH       = 4,
  parameter int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS),
  parameter int DEPTH_WIDTH       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic                   i_counter_enable,
  input  logic                   i_jump,
  input  logic                   i_call,
  input  logic                   i_ret,
  input  logic                   i_halt,
  input  logic                   i_adv,
  input  logic [PC_WIDTH-1:0]    i_load_data,
  output logic [PC_WIDTH-1:0]    o_program_counter,
  output logic [STEP_WIDTH-1:0]  o_step,
  output logic [DEPTH_WIDTH-1:0] o_stack_depth,
  output logic                   o_halted,
  output logic                   o_fault
);

  localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

  seq_state_t            state;
  pc_action_t            action;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   stack_top;
  logic [STEP_WIDTH-1:0] step;
  logic                  run_en;
  logic                  push;
  logic                  pop;
  logic                  stack_full;
  logic                  stack_empty;

  assign run_en = clk_en && (state == ST_RUN);
  assign action = decode_action(i_halt, i_ret, i_call, i_jump, i_counter_enable);
  assign push   = run_en && (action == ACT_CALL) && !stack_full;
  assign pop    = run_en && (action == ACT_RET) && !stack_empty;

  call_stack #(
    .WIDTH       (PC_WIDTH),
    .DEPTH       (STACK_DEPTH),
    .DEPTH_WIDTH (DEPTH_WIDTH)
  ) u_call_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .top       (stack_top),
    .depth     (o_stack_depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      pc       <= '0;
      step     <= '0;
      o_halted <= 1'b0;
      o_fault  <= 1'b0;
    end else if (run_en) begin
      // The step counter keeps running on fault cycles; only halt freezes it.
      if (action != ACT_HALT)
        step <= (i_adv || step == STEP_LAST) ? '0 : step + 1'b1;
      case (action)
        ACT_HALT: begin
          state    <= ST_HALTED;
          o_halted <= 1'b1;
        end
        ACT_RET: begin
          if (stack_empty) begin
            state   <= ST_FAULT;
            o_fault <= 1'b1;
          end else begin
            pc <= stack_top;
          end
        end
        ACT_CALL: begin
          if (stack_full) begin
            state   <= ST_FAULT;
            o_fault <= 1'b1;
          end else begin
            pc <= i_load_data;
          end
        end
        ACT_JUMP: pc <= i_load_data;
        ACT_INC:  pc <= pc + 1'b1;
        default:  ;
      endcase
    end
  end

  assign o_program_counter = pc;
  assign o_step            = step;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboarded bench for program_sequencer: stimulus pushes model predictions,
// a monitor pops and compares them shortly after each rising edge.
module tb_program_sequencer;

  localparam int PCW   = 4;
  localparam int STEPS = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       counter_enable;
  logic       jump;
  logic       call;
  logic       ret;
  logic       halt;
  logic       adv;
  logic [3:0] load_data;
  logic [3:0] program_counter;
  logic [2:0] step;
  logic [2:0] stack_depth;
  logic       halted;
  logic       fault;

  program_sequencer #(
    .PC_WIDTH          (PCW),
    .INSTRUCTION_STEPS (STEPS),
    .STACK_DEPTH       (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .clk_en            (clk_en),
    .i_counter_enable  (counter_enable),
    .i_jump            (jump),
    .i_call            (call),
    .i_ret             (ret),
    .i_halt            (halt),
    .i_adv             (adv),
    .i_load_data       (load_data),
    .o_program_counter (program_counter),
    .o_step            (step),
    .o_stack_depth     (stack_depth),
    .o_halted          (halted),
    .o_fault           (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int stp;
    int depth;
    int halted;
    int fault;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode 0 = running, 1 = halted, 2 = faulted.
  int m_pc, m_step, m_mode;
  int m_stk[$];

  function automatic exp_t snapshot();
    exp_t e;
    e.pc     = m_pc;
    e.stp    = m_step;
    e.depth  = m_stk.size();
    e.halted = (m_mode == 1) ? 1 : 0;
    e.fault  = (m_mode == 2) ? 1 : 0;
    return e;
  endfunction

  task automatic model_reset();
    m_pc   = 0;
    m_step = 0;
    m_mode = 0;
    m_stk.delete();
  endtask

  task automatic model_apply(input bit ce, input bit inc, input bit jmp, input bit cl,
                             input bit rt, input bit hl, input bit ad, input int data);
    int nstep;
    if (!ce || m_mode != 0) return;
    nstep = hl ? m_step : ((ad || m_step == STEPS - 1) ? 0 : m_step + 1);
    if (hl) m_mode = 1;
    else if (rt) begin
      if (m_stk.size() == 0) m_mode = 2;
      else m_pc = m_stk.pop_back();
    end else if (cl) begin
      if (m_stk.size() == DEPTH) m_mode = 2;
      else begin
        m_stk.push_back(m_pc);
        m_pc = data;
      end
    end else if (jmp) m_pc = data;
    else if (inc) m_pc = (m_pc + 1) % (1 << PCW);
    m_step = nstep;
  endtask

  // Negative expected fields are don't-care.
  task automatic check_out(input string name, input exp_t e);
    bit ok;
    ok = (e.pc < 0 || int'(program_counter) == e.pc) &&
         (e.stp < 0 || int'(step) == e.stp) &&
         (e.depth < 0 || int'(stack_depth) == e.depth) &&
         (e.halted < 0 || int'(halted) == e.halted) &&
         (e.fault < 0 || int'(fault) == e.fault);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s @%0t: got pc=%0d step=%0d depth=%0d halted=%0d fault=%0d, want pc=%0d step=%0d depth=%0d halted=%0d fault=%0d",
               name, $time, program_counter, step, stack_depth, halted, fault,
               e.pc, e.stp, e.depth, e.halted, e.fault);
    end
  endtask

  task automatic check_now(input string name, input int pc, input int stp, input int depth,
                           input int hl, input int flt);
    exp_t e;
    e.pc = pc; e.stp = stp; e.depth = depth; e.halted = hl; e.fault = flt;
    #3;
    check_out(name, e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_out("cycle", e);
      end
    end
  end

  task automatic cycle(input bit ce, input bit inc, input bit jmp, input bit cl,
                       input bit rt, input bit hl, input bit ad, input int data);
    @(negedge clk);
    clk_en = ce; counter_enable = inc; jump = jmp; call = cl;
    ret = rt; halt = hl; adv = ad; load_data = 4'(data);
    model_apply(ce, inc, jmp, cl, rt, hl, ad, data);
    sb.push_back(snapshot());
    @(posedge clk);
  endtask

  task automatic rand_cycle(input int halt_odds);
    cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, halt_odds - 1) == 0,
          $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
  endtask

  // kind: 0 idle, 1 reset during a call, 2 reset during a return.
  task automatic do_reset(input int kind);
    exp_t z;
    @(negedge clk);
    clk_en = 1'b1; counter_enable = 1'b1; jump = 1'b0; halt = 1'b0; adv = 1'b0;
    call = (kind == 1); ret = (kind == 2); load_data = 4'($urandom_range(0, 15));
    #2 rst = 1'b1;
    z.pc = 0; z.stp = 0; z.depth = 0; z.halted = 0; z.fault = 0;
    #1 check_out("async_reset", z);
    model_reset();
    @(negedge clk);
    clk_en = 1'b0; counter_enable = 1'b0; call = 1'b0; ret = 1'b0;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit, got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1; clk_en = 1'b0; counter_enable = 1'b0; jump = 1'b0; call = 1'b0;
    ret = 1'b0; halt = 1'b0; adv = 1'b0; load_data = '0;
    model_reset();
    #12;
    check_now("reset_state", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Counting run: PC wraps 15 -> 0 and step wraps 7 -> 0.
    for (int i = 0; i < 17; i++) begin
      cycle(1, 1, 0, 0, 0, 0, 0, 0);
      if (i == 15) check_now("pc_wrap", 0, 0, 0, 0, 0);
    end
    check_now("pc_after_17", 1, 1, 0, 0, 0);

    cycle(1, 1, 1, 0, 0, 0, 0, 9);
    check_now("jump_over_inc", 9, 2, 0, 0, 0);

    cycle(1, 0, 1, 0, 0, 0, 0, 3);
    cycle(1, 0, 0, 1, 0, 0, 0, 12);
    check_now("call_target", 12, -1, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0, 0);
    check_now("ret_restore", 3, -1, 0, 0, 0);

    // Stack overflow on the fifth call.
    do_reset(0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 0, 0, 0, 5 + i);
    check_now("overflow", 8, 5, 4, 0, 1);
    for (int i = 0; i < 10; i++) rand_cycle(8);
    check_now("fault_frozen", 8, 5, 4, 0, 1);

    do_reset(0);
    cycle(1, 0, 0, 0, 1, 0, 0, 0);
    check_now("underflow", 0, 1, 0, 0, 1);

    do_reset(0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 0, 0);
    check_now("halt_entry", 3, 3, 0, 1, 0);
    for (int i = 0; i < 20; i++) rand_cycle(4);
    check_now("halt_frozen", 3, 3, 0, 1, 0);

    // Resets landing on call and return cycles.
    do_reset(1);
    cycle(1, 0, 0, 1, 0, 0, 0, 7);
    do_reset(2);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      do_reset(int'($urandom_range(0, 2)));
      for (int i = 0; i < 150; i++) rand_cycle(80);
    end

    repeat (3) @(posedge clk);
    #4;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
